// File: rtl/grf_nr_sb_if.sv
// Register-file port bundle: write/scoreboard request side driven by the master, read data and status by the slave.
interface grf_nr_sb_if #(
  parameter int DW  = 32,
  parameter int AW  = 4,
  parameter int NRD = 2
);
  logic              i_clk_en;
  logic              i_cs_b;
  logic [AW-1:0]     i_waddr;
  logic [DW/8-1:0]   i_wen;
  logic [DW-1:0]     i_din;
  logic              i_wlast;
  logic [NRD*AW-1:0] i_raddr;
  logic [NRD*DW-1:0] o_dout;
  logic [NRD-1:0]    o_busy;
  logic              i_sb_set;
  logic [AW-1:0]     i_sb_addr;
  logic              o_ready;

  modport master (
    output i_clk_en, i_cs_b, i_waddr, i_wen, i_din, i_wlast, i_raddr, i_sb_set, i_sb_addr,
    input  o_dout, o_busy, o_ready
  );

  modport slave (
    input  i_clk_en, i_cs_b, i_waddr, i_wen, i_din, i_wlast, i_raddr, i_sb_set, i_sb_addr,
    output o_dout, o_busy, o_ready
  );
endinterface

// File: rtl/grf_nr_sb.sv
// Register file with byte-enable write, NRD async read ports with write-through bypass, and busy scoreboard.
// Reads 0 cycles, writes 1 cycle; no backpressure: until o_ready the post-reset clear runs and all requests are dropped.
module grf_nr_sb #(
  parameter int DW      = 32,
  parameter int AW      = 4,
  parameter int NRD     = 2,
  parameter int R0_ZERO = 0,
  parameter int BYPASS  = 1
) (
  input  logic         i_clk,
  input  logic         i_rst,
  grf_nr_sb_if.slave   bus
);
  localparam int NREGS = 1 << AW;
  localparam int NB    = DW / 8;

  localparam logic [0:0] ST_INIT = 1'b0;
  localparam logic [0:0] ST_RUN  = 1'b1;

  logic [0:0]       state;
  logic [AW-1:0]    init_cnt;
  logic [DW-1:0]    rf [NREGS];
  logic [NREGS-1:0] busy;

  logic             run;
  logic             wr;
  logic             clr;
  logic             sb_ok;
  logic             setsame;
  logic [DW-1:0]    merged;
  logic [NRD*DW-1:0] dout_v;
  logic [NRD-1:0]   busy_v;
  logic [AW-1:0]    ra;

  assign run = (state == ST_RUN);

  // R0 writes and scoreboard sets are squashed here so R0 can never hold data or go busy.
  assign wr      = run && bus.i_clk_en && !bus.i_cs_b && (|bus.i_wen)
                   && !((R0_ZERO != 0) && (bus.i_waddr == '0));
  assign clr     = wr && bus.i_wlast;
  assign sb_ok   = run && bus.i_clk_en && bus.i_sb_set
                   && !((R0_ZERO != 0) && (bus.i_sb_addr == '0));
  assign setsame = sb_ok && (bus.i_sb_addr == bus.i_waddr);

  always_comb begin
    merged = rf[bus.i_waddr];
    for (int b = 0; b < NB; b++) begin
      if (bus.i_wen[b]) merged[b*8 +: 8] = bus.i_din[b*8 +: 8];
    end
  end

  always_comb begin
    dout_v = '0;
    busy_v = '0;
    ra     = '0;
    for (int k = 0; k < NRD; k++) begin
      ra = bus.i_raddr[k*AW +: AW];
      if (run && !((R0_ZERO != 0) && (ra == '0))) begin
        if ((BYPASS != 0) && wr && (bus.i_waddr == ra)) dout_v[k*DW +: DW] = merged;
        else                                            dout_v[k*DW +: DW] = rf[ra];
        // A clearing writeback is visible in the same cycle, unless a same-address set overrides it.
        busy_v[k] = busy[ra] && !(clr && (bus.i_waddr == ra) && !setsame);
      end
    end
  end

  assign bus.o_dout  = dout_v;
  assign bus.o_busy  = busy_v;
  assign bus.o_ready = run;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state    <= ST_INIT;
      init_cnt <= '0;
      busy     <= '0;
    end else if (bus.i_clk_en) begin
      if (state == ST_INIT) begin
        init_cnt <= init_cnt + 1'b1;
        if (&init_cnt) state <= ST_RUN;
      end else begin
        if (clr)   busy[bus.i_waddr]   <= 1'b0;
        if (sb_ok) busy[bus.i_sb_addr] <= 1'b1;
      end
    end
  end

  // Storage has no reset; the INIT walk zeroes it one entry per enabled cycle.
  always_ff @(posedge i_clk) begin
    if (bus.i_clk_en) begin
      if (state == ST_INIT) rf[init_cnt]    <= '0;
      else if (wr)          rf[bus.i_waddr] <= merged;
    end
  end
endmodule

// File: tb/tb_grf_nr_sb.sv
// Directed, table-driven bench for grf_nr_sb: default config (A) and R0_ZERO/NRD=3 config (B).
module tb_grf_nr_sb;
  logic clk;
  logic rst;
  int   n_chk;
  int   n_fail;

  grf_nr_sb_if #(.DW(32), .AW(4), .NRD(2)) ifa ();
  grf_nr_sb_if #(.DW(32), .AW(4), .NRD(3)) ifb ();

  grf_nr_sb #(.DW(32), .AW(4), .NRD(2), .R0_ZERO(0), .BYPASS(1)) u_a (
    .i_clk(clk), .i_rst(rst), .bus(ifa)
  );
  grf_nr_sb #(.DW(32), .AW(4), .NRD(3), .R0_ZERO(1), .BYPASS(1)) u_b (
    .i_clk(clk), .i_rst(rst), .bus(ifb)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    logic        en;
    logic        cs_b;
    logic [3:0]  waddr;
    logic [3:0]  wen;
    logic [31:0] din;
    logic        wlast;
    logic        sb;
    logic [3:0]  sba;
    logic [3:0]  ra0;
    logic [3:0]  ra1;
    logic [31:0] e0;
    logic [31:0] e1;
    logic [1:0]  eb;
  } vec_t;

  vec_t vec [12];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  task automatic a_idle();
    ifa.i_clk_en  = 1'b1;
    ifa.i_cs_b    = 1'b1;
    ifa.i_waddr   = '0;
    ifa.i_wen     = '0;
    ifa.i_din     = '0;
    ifa.i_wlast   = 1'b0;
    ifa.i_sb_set  = 1'b0;
    ifa.i_sb_addr = '0;
  endtask

  task automatic b_idle();
    ifb.i_clk_en  = 1'b1;
    ifb.i_cs_b    = 1'b1;
    ifb.i_waddr   = '0;
    ifb.i_wen     = '0;
    ifb.i_din     = '0;
    ifb.i_wlast   = 1'b0;
    ifb.i_sb_set  = 1'b0;
    ifb.i_sb_addr = '0;
  endtask

  // Counts edges until DUT A reports ready; with toggle, clk_en is high only on even-numbered edges.
  task automatic wait_ready(input int exp_e, input logic toggle, input string nm);
    int got;
    int bad;
    got = -1;
    bad = 0;
    for (int e = 1; e <= 100; e++) begin
      ifa.i_clk_en = toggle ? ((e % 2) == 0) : 1'b1;
      #1;
      if (ifa.o_ready !== 1'b0 || ifa.o_dout !== 64'h0 || ifa.o_busy !== 2'b00) bad++;
      @(posedge clk);
      #1;
      if (ifa.o_ready === 1'b1) begin
        got = e;
        break;
      end
    end
    a_idle();
    chk({nm, " edges_to_ready"}, got, exp_e);
    chk({nm, " init_outputs_quiet"}, bad, 0);
  endtask

  initial begin
    n_chk  = 0;
    n_fail = 0;
    rst    = 1'b1;
    a_idle();
    b_idle();
    ifa.i_raddr = {4'd5, 4'd3};
    ifb.i_raddr = {4'd0, 4'd0, 4'd0};

    vec[0]  = '{1'b1, 1'b0, 4'd3, 4'hF, 32'hDEADBEEF, 1'b0, 1'b0, 4'd0, 4'd3, 4'd3, 32'hDEADBEEF, 32'hDEADBEEF, 2'b00};
    vec[1]  = '{1'b1, 1'b0, 4'd3, 4'h2, 32'h00001200, 1'b0, 1'b0, 4'd0, 4'd3, 4'd4, 32'hDEAD12EF, 32'h00000000, 2'b00};
    vec[2]  = '{1'b1, 1'b1, 4'd0, 4'h0, 32'h00000000, 1'b0, 1'b1, 4'd5, 4'd3, 4'd5, 32'hDEAD12EF, 32'h00000000, 2'b00};
    vec[3]  = '{1'b1, 1'b0, 4'd5, 4'hF, 32'h11111111, 1'b0, 1'b0, 4'd0, 4'd3, 4'd5, 32'hDEAD12EF, 32'h11111111, 2'b10};
    vec[4]  = '{1'b1, 1'b0, 4'd5, 4'h1, 32'h000000AA, 1'b1, 1'b0, 4'd0, 4'd5, 4'd5, 32'h111111AA, 32'h111111AA, 2'b00};
    vec[5]  = '{1'b1, 1'b1, 4'd0, 4'h0, 32'h00000000, 1'b0, 1'b0, 4'd0, 4'd5, 4'd5, 32'h111111AA, 32'h111111AA, 2'b00};
    vec[6]  = '{1'b1, 1'b0, 4'd7, 4'hF, 32'h77777777, 1'b1, 1'b1, 4'd7, 4'd7, 4'd7, 32'h77777777, 32'h77777777, 2'b00};
    vec[7]  = '{1'b1, 1'b1, 4'd0, 4'h0, 32'h00000000, 1'b0, 1'b0, 4'd0, 4'd7, 4'd3, 32'h77777777, 32'hDEAD12EF, 2'b01};
    vec[8]  = '{1'b1, 1'b0, 4'd3, 4'h0, 32'hFFFFFFFF, 1'b1, 1'b0, 4'd0, 4'd3, 4'd7, 32'hDEAD12EF, 32'h77777777, 2'b10};
    vec[9]  = '{1'b1, 1'b1, 4'd0, 4'h0, 32'h00000000, 1'b0, 1'b0, 4'd0, 4'd3, 4'd7, 32'hDEAD12EF, 32'h77777777, 2'b10};
    vec[10] = '{1'b0, 1'b0, 4'd7, 4'hF, 32'h00000000, 1'b1, 1'b1, 4'd2, 4'd7, 4'd7, 32'h77777777, 32'h77777777, 2'b11};
    vec[11] = '{1'b1, 1'b1, 4'd0, 4'h0, 32'h00000000, 1'b0, 1'b0, 4'd0, 4'd7, 4'd2, 32'h77777777, 32'h00000000, 2'b01};

    // Power-on init with clk_en held high: 16 edges.
    #22;
    rst = 1'b0;
    wait_ready(16, 1'b0, "init1");
    chk("b_ready_after_init1", {31'd0, ifb.o_ready}, 32'd1);

    for (int i = 0; i < 12; i++) begin
      ifa.i_clk_en  = vec[i].en;
      ifa.i_cs_b    = vec[i].cs_b;
      ifa.i_waddr   = vec[i].waddr;
      ifa.i_wen     = vec[i].wen;
      ifa.i_din     = vec[i].din;
      ifa.i_wlast   = vec[i].wlast;
      ifa.i_sb_set  = vec[i].sb;
      ifa.i_sb_addr = vec[i].sba;
      ifa.i_raddr   = {vec[i].ra1, vec[i].ra0};
      #2;
      chk($sformatf("v%0d dout0", i), ifa.o_dout[31:0], vec[i].e0);
      chk($sformatf("v%0d dout1", i), ifa.o_dout[63:32], vec[i].e1);
      chk($sformatf("v%0d busy", i), {30'd0, ifa.o_busy}, {30'd0, vec[i].eb});
      @(posedge clk);
      #1;
    end
    a_idle();

    // Config B: R0 hard-wired to zero, three ports aliasing one address.
    ifb.i_cs_b    = 1'b0;
    ifb.i_waddr   = 4'd0;
    ifb.i_wen     = 4'hF;
    ifb.i_din     = 32'hFFFFFFFF;
    ifb.i_sb_set  = 1'b1;
    ifb.i_sb_addr = 4'd0;
    ifb.i_raddr   = {4'd0, 4'd0, 4'd0};
    #2;
    chk("b_r0_write_dout", ifb.o_dout[31:0] | ifb.o_dout[63:32] | ifb.o_dout[95:64], 32'h0);
    chk("b_r0_write_busy", {29'd0, ifb.o_busy}, 32'h0);
    @(posedge clk);
    #1;
    b_idle();
    #2;
    chk("b_r0_after_dout", ifb.o_dout[31:0] | ifb.o_dout[63:32] | ifb.o_dout[95:64], 32'h0);
    chk("b_r0_after_busy", {29'd0, ifb.o_busy}, 32'h0);
    ifb.i_cs_b  = 1'b0;
    ifb.i_waddr = 4'd9;
    ifb.i_wen   = 4'hF;
    ifb.i_din   = 32'h12345678;
    ifb.i_raddr = {4'd9, 4'd9, 4'd9};
    #2;
    chk("b_alias_byp_p0", ifb.o_dout[31:0], 32'h12345678);
    chk("b_alias_byp_p1", ifb.o_dout[63:32], 32'h12345678);
    chk("b_alias_byp_p2", ifb.o_dout[95:64], 32'h12345678);
    @(posedge clk);
    #1;
    b_idle();
    #2;
    chk("b_alias_st_p0", ifb.o_dout[31:0], 32'h12345678);
    chk("b_alias_st_p1", ifb.o_dout[63:32], 32'h12345678);
    chk("b_alias_st_p2", ifb.o_dout[95:64], 32'h12345678);

    // Mid-RUN reset with R7 busy: ready and busy drop without a clock edge.
    ifa.i_raddr = {4'd5, 4'd7};
    #1;
    chk("pre_rst_busy", {30'd0, ifa.o_busy}, 32'd1);
    rst = 1'b1;
    #1;
    chk("rst_ready_drop", {31'd0, ifa.o_ready}, 32'd0);
    chk("rst_busy_drop", {30'd0, ifa.o_busy}, 32'd0);
    #1;
    rst = 1'b0;
    ifa.i_cs_b    = 1'b0;
    ifa.i_waddr   = 4'd3;
    ifa.i_wen     = 4'hF;
    ifa.i_din     = 32'hFFFFFFFF;
    ifa.i_wlast   = 1'b0;
    ifa.i_sb_set  = 1'b1;
    ifa.i_sb_addr = 4'd3;
    ifa.i_raddr   = {4'd3, 4'd3};
    wait_ready(32, 1'b1, "init2");

    for (int r = 0; r < 16; r++) begin
      ifa.i_raddr = {4'(15 - r), 4'(r)};
      #1;
      chk($sformatf("reinit r%0d", r), ifa.o_dout[31:0], 32'h0);
      chk($sformatf("reinit busy r%0d", r), {30'd0, ifa.o_busy}, 32'h0);
    end

    $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
    $finish;
  end
endmodule
